updown_sweep_controller: RTL

- Sequencing controller for a WIDTH-bit synchronous up/down counter datapath. The counter is held inside this block.
- Takes a programmed window [lo, hi], a sweep mode and a pass count, then steps the counter one value per enabled clock.
- Wraps or reverses at the window edges and reports completion.
- Sits between a control/config source and any logic that consumes a swept index (address sweeps, PWM ramps, scan sequencing).

---
 rtl/updown_sweep_controller_if.sv | 30 +++
 rtl/updown_sweep_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/updown_sweep_controller_if.sv
// Control/config and status bundle for the up/down sweep controller.
// The config source uses master; the controller uses slave.
interface updown_sweep_controller_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
);
  logic              start;
  logic              abort;
  logic              hold;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PASS_W-1:0] passes;
  logic [WIDTH-1:0]  count;
  logic              dir;
  logic              busy;
  logic              done;
  logic              turn;
  logic              err;

  modport master (
    output start, abort, hold, mode, lo, hi, passes,
    input  count, dir, busy, done, turn, err
  );

  modport slave (
    input  start, abort, hold, mode, lo, hi, passes,
    output count, dir, busy, done, turn, err
  );
endinterface

// File: rtl/updown_sweep_controller.sv
// Windowed up/down sweep sequencer: steps a held counter through [lo, hi]
// with wrap or bounce turnaround, a pass limit, hold and abort.
//
// state | meaning
// IDLE  | waiting for an accepted start; count/dir keep their last values
// RUN   | stepping one value per cycle with hold low
module updown_sweep_controller #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  updown_sweep_controller_if.slave  sif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [WIDTH-1:0]  lo_q, lo_nxt;
  logic [WIDTH-1:0]  hi_q, hi_nxt;
  logic [PASS_W-1:0] passes_q, passes_nxt;
  logic [PASS_W-1:0] pass_q, pass_nxt;
  logic [WIDTH-1:0]  count_q, count_nxt;
  logic              dir_q, dir_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              turn_q, turn_nxt;
  logic              err_q, err_nxt;

  logic start_req;
  logic window_ok;
  logic at_end;
  logic last_pass;

  assign start_req = sif.start && !sif.abort;
  assign window_ok = (sif.lo <= sif.hi);
  assign at_end    = dir_q ? (count_q == lo_q) : (count_q == hi_q);
  // passes=0 never reaches a final pass, so the sweep only ends on abort
  assign last_pass = (passes_q != '0) && (pass_q == passes_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      turn_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      mode_q   <= mode_nxt;
      lo_q     <= lo_nxt;
      hi_q     <= hi_nxt;
      passes_q <= passes_nxt;
      pass_q   <= pass_nxt;
      count_q  <= count_nxt;
      dir_q    <= dir_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      turn_q   <= turn_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (start_req && window_ok) state_nxt = RUN;
      RUN: begin
        if (sif.abort)                             state_nxt = IDLE;
        else if (!sif.hold && at_end && last_pass) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mode_nxt   = mode_q;
    lo_nxt     = lo_q;
    hi_nxt     = hi_q;
    passes_nxt = passes_q;
    pass_nxt   = pass_q;
    count_nxt  = count_q;
    dir_nxt    = dir_q;
    done_nxt   = 1'b0;
    turn_nxt   = 1'b0;
    err_nxt    = 1'b0;
    busy_nxt   = (state_nxt == RUN);
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (window_ok) begin
            mode_nxt   = sif.mode;
            lo_nxt     = sif.lo;
            hi_nxt     = sif.hi;
            passes_nxt = sif.passes;
            pass_nxt   = PASS_W'(1);
            dir_nxt    = sif.mode[0];
            count_nxt  = sif.mode[0] ? sif.hi : sif.lo;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (!sif.abort && !sif.hold) begin
          if (!at_end) begin
            count_nxt = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
          end else if (last_pass) begin
            done_nxt = 1'b1;
          end else begin
            turn_nxt = 1'b1;
            if (passes_q != '0) pass_nxt = pass_q + 1'b1;
            if (!mode_q[1]) begin
              count_nxt = dir_q ? hi_q : lo_q;
            end else begin
              // Bounce steps back off the end point so it is not repeated,
              // except for a single-value window where there is nowhere to go.
              dir_nxt = !dir_q;
              if (lo_q != hi_q)
                count_nxt = dir_q ? (count_q + 1'b1) : (count_q - 1'b1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign sif.count = count_q;
  assign sif.dir   = dir_q;
  assign sif.busy  = busy_q;
  assign sif.done  = done_q;
  assign sif.turn  = turn_q;
  assign sif.err   = err_q;

endmodule
